// File: rtl/hazard_scoreboard_pkg.sv
// Shared opcode/funct constants and forwarding-select encodings for the hazard scoreboard.
package hazard_scoreboard_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FUNCT_SLL   = 6'h00;
  localparam logic [5:0] FUNCT_SRL   = 6'h02;
  localparam logic [5:0] FUNCT_SRA   = 6'h03;
  localparam logic [5:0] FUNCT_JR    = 6'h08;
  localparam logic [5:0] FUNCT_JALR  = 6'h09;
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1a;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1b;
  localparam logic [5:0] FUNCT_ADDU  = 6'h21;

  localparam logic [1:0] FWD_RF   = 2'd0;
  localparam logic [1:0] FWD_AGE0 = 2'd1;
  localparam logic [1:0] FWD_AGE1 = 2'd2;
  localparam logic [1:0] FWD_AGE2 = 2'd3;

  function automatic logic [1:0] age_to_sel(input int age);
    case (age)
      0:       return FWD_AGE0;
      1:       return FWD_AGE1;
      default: return FWD_AGE2;
    endcase
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-stage <-> scoreboard bundle: ID instruction fields in, stall/forward/busy out.
interface hazard_scoreboard_if #(parameter int REG_AW = 5);
  logic              id_valid;
  logic [5:0]        id_opcode;
  logic [5:0]        id_funct;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic [REG_AW-1:0] id_dest;
  logic              id_reg_write;
  logic              id_flush;
  logic              stall;
  logic [1:0]        fwd_rs_sel;
  logic [1:0]        fwd_rt_sel;
  logic              md_busy;

  modport master (
    output id_valid, id_opcode, id_funct, id_rs, id_rt, id_dest, id_reg_write, id_flush,
    input  stall, fwd_rs_sel, fwd_rt_sel, md_busy
  );

  modport slave (
    input  id_valid, id_opcode, id_funct, id_rs, id_rt, id_dest, id_reg_write, id_flush,
    output stall, fwd_rs_sel, fwd_rt_sel, md_busy
  );
endinterface

// File: rtl/hazard_scoreboard_src_decode.sv
// Combinational opcode/funct decode into source-use, load and MULT/DIV flags.
module hazard_src_decode
  import hazard_scoreboard_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       use_rs,
  output logic       use_rt,
  output logic       is_load,
  output logic       md_start,
  output logic       md_read
);

  assign is_load = (opcode == OP_LW);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
    use_rs   = 1'b0;
    use_rt   = 1'b0;
    md_start = 1'b0;
    md_read  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FUNCT_SLL, FUNCT_SRL, FUNCT_SRA:            use_rt = 1'b1;
          FUNCT_JR, FUNCT_JALR, FUNCT_MTHI, FUNCT_MTLO: use_rs = 1'b1;
          FUNCT_MFHI, FUNCT_MFLO:                     md_read = 1'b1;
          FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: begin
            use_rs   = 1'b1;
            use_rt   = 1'b1;
            md_start = 1'b1;
          end
          default: begin
            use_rs = 1'b1;
            use_rt = 1'b1;
          end
        endcase
      end
      OP_BEQ, OP_BNE, OP_SW: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      OP_BLEZ, OP_BGTZ, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LW:
        use_rs = 1'b1;
      default: ;  // J, JAL, LUI read no GPR
    endcase
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: shadow of in-flight destinations (EX..WB), stall/forward selection and
// a MULT/DIV busy counter, all evaluated against the instruction sitting in ID.
module hazard_scoreboard #(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3,
  parameter int FWD_EN = 1,
  parameter int MD_LAT = 4
) (
  input logic clk,
  input logic reset,
  hazard_scoreboard_if.slave bus
);
  import hazard_scoreboard_pkg::*;

  localparam int CNT_W = $clog2(MD_LAT + 1);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dest;
    logic              is_load;
  } entry_t;

  entry_t            shadow [DEPTH];
  entry_t            new_entry;
  logic [CNT_W-1:0]  md_cnt;
  logic              use_rs, use_rt, is_load, md_start, md_read;
  logic [DEPTH-1:0]  rs_match, rt_match;
  logic [1:0]        rs_sel, rt_sel;
  logic              hazard, stall, id_issue;

  hazard_src_decode u_decode (
    .opcode   (bus.id_opcode),
    .funct    (bus.id_funct),
    .use_rs   (use_rs),
    .use_rt   (use_rt),
    .is_load  (is_load),
    .md_start (md_start),
    .md_read  (md_read)
  );

  always_comb begin
    rs_match = '0;
    rt_match = '0;
    for (int k = 0; k < DEPTH; k++) begin
      rs_match[k] = shadow[k].valid && (shadow[k].dest == bus.id_rs) && (bus.id_rs != '0);
      rt_match[k] = shadow[k].valid && (shadow[k].dest == bus.id_rt) && (bus.id_rt != '0);
    end
  end

  // Walk oldest to youngest so the youngest matching age ends up selected.
  always_comb begin
    rs_sel = FWD_RF;
    rt_sel = FWD_RF;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (rs_match[k]) rs_sel = age_to_sel(k);
      if (rt_match[k]) rt_sel = age_to_sel(k);
    end
    if (FWD_EN == 0 || !use_rs) rs_sel = FWD_RF;
    if (FWD_EN == 0 || !use_rt) rt_sel = FWD_RF;
  end

  always_comb begin
    if (FWD_EN != 0)
      hazard = ((use_rs && rs_match[0]) || (use_rt && rt_match[0])) && shadow[0].is_load;
    else
      hazard = (use_rs && (|rs_match)) || (use_rt && (|rt_match));
    stall = bus.id_valid && (hazard || ((md_read || md_start) && (md_cnt != '0)));
  end

  // A flushed instruction is never entered even though stall may still be reported.
  assign id_issue = bus.id_valid && !stall && !bus.id_flush;

  always_comb begin
    new_entry = '0;
    if (id_issue) begin
      new_entry.valid   = bus.id_reg_write && (bus.id_dest != '0);
      new_entry.dest    = bus.id_dest;
      new_entry.is_load = is_load;
    end
  end

  // NOTE: the shadow is a register array, not a RAM, and is cleared on reset because its valid
  // bits directly gate stall; uncleared entries would fabricate hazards after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) shadow[k] <= '0;
    end else begin
      // NOTE: non-blocking assignments make every entry shift from its pre-edge value.
      shadow[0] <= new_entry;
      for (int k = 1; k < DEPTH; k++) shadow[k] <= shadow[k-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                     md_cnt <= '0;
    else if (id_issue && md_start) md_cnt <= CNT_W'(MD_LAT);
    else if (md_cnt != '0)         md_cnt <= md_cnt - 1'b1;
  end

  assign bus.stall      = stall;
  assign bus.fwd_rs_sel = rs_sel;
  assign bus.fwd_rt_sel = rt_sel;
  assign bus.md_busy    = (md_cnt != '0);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: a forwarding instance (FWD_EN=1) and a stall-only instance (FWD_EN=0) share stimulus.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_AW(5)) bus_f1 ();
  hazard_scoreboard_if #(.REG_AW(5)) bus_s0 ();

  hazard_scoreboard #(.REG_AW(5), .DEPTH(3), .FWD_EN(1), .MD_LAT(4)) dut_f1 (
    .clk(clk), .reset(reset), .bus(bus_f1)
  );
  hazard_scoreboard #(.REG_AW(5), .DEPTH(3), .FWD_EN(0), .MD_LAT(4)) dut_s0 (
    .clk(clk), .reset(reset), .bus(bus_s0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_f1(input string tag, input logic s, input logic [1:0] rs, input logic [1:0] rt,
                        input logic b);
    check({tag, ".f1.stall"}, 32'(bus_f1.stall), 32'(s));
    check({tag, ".f1.rs_sel"}, 32'(bus_f1.fwd_rs_sel), 32'(rs));
    check({tag, ".f1.rt_sel"}, 32'(bus_f1.fwd_rt_sel), 32'(rt));
    check({tag, ".f1.md_busy"}, 32'(bus_f1.md_busy), 32'(b));
  endtask

  task automatic chk_s0(input string tag, input logic s, input logic [1:0] rs, input logic [1:0] rt);
    check({tag, ".s0.stall"}, 32'(bus_s0.stall), 32'(s));
    check({tag, ".s0.rs_sel"}, 32'(bus_s0.fwd_rs_sel), 32'(rs));
    check({tag, ".s0.rt_sel"}, 32'(bus_s0.fwd_rt_sel), 32'(rt));
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dest,
                       input logic rw, input logic fl);
    bus_f1.id_valid = v;  bus_f1.id_opcode = op; bus_f1.id_funct = fn;
    bus_f1.id_rs = rs;    bus_f1.id_rt = rt;     bus_f1.id_dest = dest;
    bus_f1.id_reg_write = rw; bus_f1.id_flush = fl;
    bus_s0.id_valid = v;  bus_s0.id_opcode = op; bus_s0.id_funct = fn;
    bus_s0.id_rs = rs;    bus_s0.id_rt = rt;     bus_s0.id_dest = dest;
    bus_s0.id_reg_write = rw; bus_s0.id_flush = fl;
  endtask

  task automatic idle();                                   drive(1'b0, OP_RTYPE, FUNCT_ADDU, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0); endtask
  task automatic addu(input logic [4:0] rd, rs, rt);       drive(1'b1, OP_RTYPE, FUNCT_ADDU, rs, rt, rd, 1'b1, 1'b0); endtask
  task automatic lw(input logic [4:0] rt, base, input logic fl); drive(1'b1, OP_LW, 6'd0, base, rt, rt, 1'b1, fl); endtask
  task automatic lui(input logic [4:0] rt);                drive(1'b1, OP_LUI, 6'd0, 5'd0, rt, rt, 1'b1, 1'b0); endtask
  task automatic mult(input logic [4:0] rs, rt);           drive(1'b1, OP_RTYPE, FUNCT_MULT, rs, rt, 5'd0, 1'b0, 1'b0); endtask
  task automatic mflo(input logic [4:0] rd);               drive(1'b1, OP_RTYPE, FUNCT_MFLO, 5'd0, 5'd0, rd, 1'b1, 1'b0); endtask

  // Leaves the bench just after a negedge with reset released and the shadow empty.
  task automatic do_reset();
    idle();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    // Reset state with a reader already presented.
    reset = 1'b1;
    addu(5'd5, 5'd2, 5'd2);
    #1 chk_f1("in_reset", 1'b0, 2'd0, 2'd0, 1'b0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    #1 chk_f1("after_release", 1'b0, 2'd0, 2'd0, 1'b0);

    // Forwarding ages in FWD mode.
    do_reset();
    addu(5'd3, 5'd1, 5'd2);           #1 chk_f1("fwd_prod", 1'b0, 2'd0, 2'd0, 1'b0);
    @(negedge clk); addu(5'd4, 5'd3, 5'd5); #1 chk_f1("fwd_age0", 1'b0, 2'd1, 2'd0, 1'b0);
    @(negedge clk); addu(5'd6, 5'd5, 5'd3); #1 chk_f1("fwd_age1", 1'b0, 2'd0, 2'd2, 1'b0);
    @(negedge clk); addu(5'd7, 5'd3, 5'd3); #1 chk_f1("fwd_age2", 1'b0, 2'd3, 2'd3, 1'b0);
    @(negedge clk); addu(5'd8, 5'd3, 5'd4); #1 chk_f1("fwd_fell_off", 1'b0, 2'd0, 2'd3, 1'b0);
    @(negedge clk); addu(5'd10, 5'd1, 5'd1);
    @(negedge clk); addu(5'd10, 5'd1, 5'd1);
    @(negedge clk); addu(5'd11, 5'd10, 5'd10); #1 chk_f1("fwd_youngest", 1'b0, 2'd1, 2'd1, 1'b0);

    // Load-use: exactly one bubble, then forward from age1.
    do_reset();
    lw(5'd2, 5'd1, 1'b0);             #1 chk_f1("lu_load", 1'b0, 2'd0, 2'd0, 1'b0);
    @(negedge clk); addu(5'd5, 5'd4, 5'd2); #1 chk_f1("lu_stall", 1'b1, 2'd0, 2'd1, 1'b0);
    @(negedge clk);                   #1 chk_f1("lu_resume", 1'b0, 2'd0, 2'd2, 1'b0);
    @(negedge clk); lw(5'd6, 5'd1, 1'b0);
    @(negedge clk); lui(5'd6);        #1 chk_f1("lu_no_use", 1'b0, 2'd0, 2'd0, 1'b0);

    // r0 producer and flushed producer never create hazards.
    do_reset();
    addu(5'd0, 5'd1, 5'd2);
    @(negedge clk); addu(5'd5, 5'd0, 5'd0);
    #1 chk_f1("r0_read", 1'b0, 2'd0, 2'd0, 1'b0);
    chk_s0("r0_read", 1'b0, 2'd0, 2'd0);
    @(negedge clk); lw(5'd9, 5'd1, 1'b1);
    @(negedge clk); addu(5'd5, 5'd9, 5'd9);
    #1 chk_f1("flushed_prod", 1'b0, 2'd0, 2'd0, 1'b0);
    chk_s0("flushed_prod", 1'b0, 2'd0, 2'd0);

    // Stall-only mode: stall for the full shadow depth, selects stay 0.
    do_reset();
    addu(5'd7, 5'd1, 5'd2);           #1 chk_s0("s0_prod", 1'b0, 2'd0, 2'd0);
    @(negedge clk); addu(5'd8, 5'd7, 5'd1);
    for (int c = 0; c < 3; c++) begin
      #1 chk_s0($sformatf("s0_stall%0d", c), 1'b1, 2'd0, 2'd0);
      @(negedge clk);
    end
    #1 chk_s0("s0_issue", 1'b0, 2'd0, 2'd0);

    // MULT then MFLO: 4 busy/stall cycles, MFLO issues on the 5th.
    do_reset();
    mult(5'd1, 5'd2);                 #1 chk_f1("md_mult", 1'b0, 2'd0, 2'd0, 1'b0);
    @(negedge clk); mflo(5'd3);
    for (int c = 0; c < 4; c++) begin
      #1 chk_f1($sformatf("md_wait%0d", c), 1'b1, 2'd0, 2'd0, 1'b1);
      @(negedge clk);
    end
    #1 chk_f1("md_mflo_issue", 1'b0, 2'd0, 2'd0, 1'b0);

    // Back-to-back MULT: second waits 4 cycles, then the counter reloads.
    @(negedge clk); mult(5'd4, 5'd5);   #1 chk_f1("md_b2b_first", 1'b0, 2'd0, 2'd0, 1'b0);
    @(negedge clk); mult(5'd6, 5'd7);
    for (int c = 0; c < 4; c++) begin
      #1 chk_f1($sformatf("md_b2b_wait%0d", c), 1'b1, 2'd0, 2'd0, 1'b1);
      @(negedge clk);
    end
    #1 chk_f1("md_b2b_issue", 1'b0, 2'd0, 2'd0, 1'b0);
    @(negedge clk); idle();           #1 chk_f1("md_reload", 1'b0, 2'd0, 2'd0, 1'b1);

    // Async reset with a pending load in age0 and the counter at 3.
    do_reset();
    mult(5'd1, 5'd2);
    @(negedge clk); lw(5'd2, 5'd1, 1'b0);
    @(negedge clk); addu(5'd5, 5'd2, 5'd2);
    #1 chk_f1("pre_reset", 1'b1, 2'd1, 2'd1, 1'b1);
    #2 reset = 1'b1;
    #1 chk_f1("mid_reset", 1'b0, 2'd0, 2'd0, 1'b0);
    @(negedge clk); reset = 1'b0;
    #1 chk_f1("post_reset_reader", 1'b0, 2'd0, 2'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
